// File: rtl/mc_fifo_bridge.sv
// mc_fifo_bridge: asynchronous MCU memory-bus slave feeding a command FIFO, draining a result FIFO,
// with a W1C status register and config registers. Optional MC_LOOPBACK_EN: cfg reg 0 bit0 = loopback.

module mc_fifo_bridge_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 16,
  parameter int CW    = $clog2(DEPTH+1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic [W-1:0]  i_data,
  output logic [W-1:0]  o_head,
  output logic [CW-1:0] o_count
);
  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0][W-1:0] r_mem;
  logic [AW-1:0]           r_rp, r_wp;
  logic [CW-1:0]           r_cnt;
  logic                    w_pop, w_push;

  // A full FIFO still accepts a push when the head leaves on the same clock.
  assign w_pop  = i_pop && (r_cnt != '0);
  assign w_push = i_push && ((r_cnt < CW'(DEPTH)) || w_pop);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_mem <= '0;
      r_rp  <= '0;
      r_wp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wp] <= i_data;
        r_wp        <= r_wp + 1'b1;
      end
      if (w_pop) r_rp <= r_rp + 1'b1;
      if (w_push && !w_pop)      r_cnt <= r_cnt + 1'b1;
      else if (w_pop && !w_push) r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_head  = r_mem[r_rp];
  assign o_count = r_cnt;
endmodule

module mc_fifo_bridge #(
  parameter int MC_DATA_WIDTH = 16,
  parameter int MC_ADD_WIDTH  = 6,
  parameter int FIFO_DEPTH    = 16,
  parameter int REG_COUNT     = 8,
  parameter int REG_BASE      = 'h10,
  parameter int SYNC_STAGES   = 2
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              mc_ce,
  input  logic                              mc_oe,
  input  logic                              mc_we,
  input  logic [MC_ADD_WIDTH-1:0]           mc_add,
  input  logic [MC_DATA_WIDTH-1:0]          mc_data_in,
  output logic [MC_DATA_WIDTH-1:0]          mc_data_out,
  output logic                              mc_data_oe,
  output logic [MC_DATA_WIDTH-1:0]          cmd_data,
  output logic                              cmd_valid,
  input  logic                              cmd_ready,
  input  logic [MC_DATA_WIDTH-1:0]          res_data,
  input  logic                              res_valid,
  output logic                              res_ready,
  output logic [REG_COUNT*MC_DATA_WIDTH-1:0] cfg_regs,
  output logic                              irq
);
  localparam int W  = MC_DATA_WIDTH;
  localparam int CW = $clog2(FIFO_DEPTH+1);
  localparam int PW = $clog2(SYNC_STAGES+2);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WCAP    = 3'd1;
  localparam logic [2:0] S_WCOMMIT = 3'd2;
  localparam logic [2:0] S_RLOAD   = 3'd3;
  localparam logic [2:0] S_RHOLD   = 3'd4;

  logic [SYNC_STAGES-1:0]      r_ce_s, r_oe_s, r_we_s;
  logic                        r_oe_d, r_we_d;
  logic [PW-1:0]               r_prime;
  logic                        w_ce, w_oe, w_we, w_primed;
  logic                        w_oe_fall, w_we_fall, w_we_rise;
  logic [2:0]                  r_state;
  logic [MC_ADD_WIDTH-1:0]     r_cap_add;
  logic [W-1:0]                r_cap_data, r_data_out, w_rd_data;
  logic [REG_COUNT-1:0][W-1:0] r_cfg;
  logic                        r_ovf, r_unf;
  logic                        w_commit, w_rd;
  logic                        w_cmd_push, w_cmd_pop, w_res_push, w_res_pop;
  logic [W-1:0]                w_cmd_head, w_res_head, w_res_din;
  logic [CW-1:0]               w_cmd_cnt, w_res_cnt;

  // Edges count only once the synchroniser holds real pad samples, so a strobe
  // already low when reset lifts never looks like an edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_ce_s  <= '1;
      r_oe_s  <= '1;
      r_we_s  <= '1;
      r_oe_d  <= 1'b1;
      r_we_d  <= 1'b1;
      r_prime <= '0;
    end else begin
      r_ce_s <= {r_ce_s[SYNC_STAGES-2:0], mc_ce};
      r_oe_s <= {r_oe_s[SYNC_STAGES-2:0], mc_oe};
      r_we_s <= {r_we_s[SYNC_STAGES-2:0], mc_we};
      r_oe_d <= w_oe;
      r_we_d <= w_we;
      if (!w_primed) r_prime <= r_prime + 1'b1;
    end
  end

  assign w_ce      = r_ce_s[SYNC_STAGES-1];
  assign w_oe      = r_oe_s[SYNC_STAGES-1];
  assign w_we      = r_we_s[SYNC_STAGES-1];
  assign w_primed  = (r_prime == PW'(SYNC_STAGES+1));
  assign w_oe_fall = w_primed && r_oe_d && !w_oe;
  assign w_we_fall = w_primed && r_we_d && !w_we;
  assign w_we_rise = w_primed && !r_we_d && w_we;
  assign mc_data_oe = !w_oe && !w_ce;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_cap_add  <= '0;
      r_cap_data <= '0;
    end else begin
      if (!w_we && !w_ce) begin
        r_cap_add  <= mc_add;
        r_cap_data <= mc_data_in;
      end
      case (r_state)
        S_IDLE: begin
          if (w_we_fall && !w_ce)      r_state <= S_WCAP;
          else if (w_oe_fall && !w_ce) r_state <= S_RLOAD;
        end
        S_WCAP:    if (w_we_rise) r_state <= w_ce ? S_IDLE : S_WCOMMIT;
        S_WCOMMIT: r_state <= S_IDLE;
        S_RLOAD:   r_state <= S_RHOLD;
        S_RHOLD:   if (w_oe) r_state <= S_IDLE;
        default:   r_state <= S_IDLE;
      endcase
    end
  end

  assign w_commit = (r_state == S_WCOMMIT);
  assign w_rd     = (r_state == S_RLOAD);

  always_comb begin
    w_rd_data = '0;
    if (mc_add == '0) begin
      if (w_res_cnt != '0) w_rd_data = w_res_head;
    end else if (mc_add == MC_ADD_WIDTH'(1)) begin
      w_rd_data = W'({w_res_cnt, w_cmd_cnt, r_ovf, r_unf});
    end else begin
      for (int i = 0; i < REG_COUNT; i++)
        if (mc_add == MC_ADD_WIDTH'(REG_BASE + i)) w_rd_data = r_cfg[i];
    end
  end

  assign w_cmd_push = w_commit && (r_cap_add == '0);
  assign w_res_pop  = w_rd && (mc_add == '0);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_data_out <= '0;
      r_cfg      <= '0;
      r_ovf      <= 1'b0;
      r_unf      <= 1'b0;
    end else begin
      // A read edge colliding with an active write returns 0.
      if (w_rd)
        r_data_out <= w_rd_data;
      else if (w_oe_fall && !w_ce && ((r_state == S_WCAP) || (r_state == S_IDLE && w_we_fall)))
        r_data_out <= '0;
      for (int i = 0; i < REG_COUNT; i++)
        if (w_commit && r_cap_add == MC_ADD_WIDTH'(REG_BASE + i)) r_cfg[i] <= r_cap_data;
      if (w_commit && r_cap_add == MC_ADD_WIDTH'(1)) begin
        if (r_cap_data[0]) r_unf <= 1'b0;
        if (r_cap_data[1]) r_ovf <= 1'b0;
      end
      if (w_cmd_push && (w_cmd_cnt == CW'(FIFO_DEPTH)) && !w_cmd_pop) r_ovf <= 1'b1;
      if (w_res_pop && (w_res_cnt == '0))                             r_unf <= 1'b1;
    end
  end

`ifdef MC_LOOPBACK_EN
  logic w_lb, w_xfer;
  assign w_lb       = r_cfg[0][0];
  assign w_xfer     = w_lb && (w_cmd_cnt != '0) && (w_res_cnt < CW'(FIFO_DEPTH));
  assign cmd_valid  = !w_lb && (w_cmd_cnt != '0);
  assign res_ready  = !w_lb && (w_res_cnt < CW'(FIFO_DEPTH));
  assign w_cmd_pop  = w_xfer || (cmd_valid && cmd_ready);
  assign w_res_push = w_xfer || (res_ready && res_valid);
  assign w_res_din  = w_xfer ? w_cmd_head : res_data;
`else
  assign cmd_valid  = (w_cmd_cnt != '0);
  assign res_ready  = (w_res_cnt < CW'(FIFO_DEPTH));
  assign w_cmd_pop  = cmd_valid && cmd_ready;
  assign w_res_push = res_ready && res_valid;
  assign w_res_din  = res_data;
`endif

  mc_fifo_bridge_fifo #(.W(W), .DEPTH(FIFO_DEPTH), .CW(CW)) u_cmd_fifo (
    .clock(clock), .reset(reset),
    .i_push(w_cmd_push), .i_pop(w_cmd_pop), .i_data(r_cap_data),
    .o_head(w_cmd_head), .o_count(w_cmd_cnt)
  );

  mc_fifo_bridge_fifo #(.W(W), .DEPTH(FIFO_DEPTH), .CW(CW)) u_res_fifo (
    .clock(clock), .reset(reset),
    .i_push(w_res_push), .i_pop(w_res_pop), .i_data(w_res_din),
    .o_head(w_res_head), .o_count(w_res_cnt)
  );

  assign mc_data_out = r_data_out;
  assign cmd_data    = w_cmd_head;
  assign cfg_regs    = r_cfg;
  assign irq         = (w_res_cnt != '0) || r_ovf || r_unf;
endmodule
